// File: rtl/regfile_dump_reader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | regfile_dump_reader_pkg : shared state encoding and sizing helpers         |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
package regfile_dump_reader_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    LOAD = 3'd2,
    SEND = 3'd3,
    WAIT = 3'd4,
    NEXT = 3'd5,
    DONE = 3'd6
  } state_t;

  function automatic int bytes_per_reg(input int nb_reg, input int nb_byte);
    return nb_reg / nb_byte;
  endfunction

  // Counter width that stays at least one bit for single-byte words.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_dump_reader_reg_word_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | reg_word_serializer : captures one register word and presents it byte by   |
// | byte, flagging the final byte. Rev 1.0                                      |
// +----------------------------------------------------------------------------+
module reg_word_serializer
  import regfile_dump_reader_pkg::*;
#(
  parameter int NB_REG    = 32,
  parameter int NB_BYTE   = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               shift,
  input  logic [NB_REG-1:0]  word,
  output logic [NB_BYTE-1:0] cur_byte,
  output logic               last_byte
);

  localparam int BPR   = bytes_per_reg(NB_REG, NB_BYTE);
  localparam int CNT_W = cnt_width(BPR);

  logic [NB_REG-1:0] shreg;
  logic [NB_REG-1:0] shifted;
  logic [CNT_W-1:0]  byte_cnt;

  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign cur_byte = shreg[NB_REG-1 -: NB_BYTE];
      assign shifted  = shreg << NB_BYTE;
    end else begin : g_lsb_first
      assign cur_byte = shreg[NB_BYTE-1:0];
      assign shifted  = shreg >> NB_BYTE;
    end
  endgenerate

  assign last_byte = (byte_cnt == CNT_W'(BPR - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg    <= '0;
      byte_cnt <= '0;
    end else if (load) begin
      shreg    <= word;
      byte_cnt <= '0;
    end else if (shift) begin
      shreg    <= shifted;
      byte_cnt <= byte_cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/regfile_dump_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | regfile_dump_reader : walks the halted register file and streams every     |
// | word to the debug TX byte interface. Rev 1.0                                |
// +----------------------------------------------------------------------------+
module regfile_dump_reader
  import regfile_dump_reader_pkg::*;
#(
  parameter int NB_REG    = 32,
  parameter int NB_ADDR   = 5,
  parameter int NB_BYTE   = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [NB_REG-1:0]  i_reg_data,
  input  logic               i_tx_done,
  output logic [NB_ADDR-1:0] o_reg_addr,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy,
  output logic               o_done
);

  // One extra bit so the final address is compared before any wrap.
  localparam logic [NB_ADDR:0] LAST_IDX = {1'b0, {NB_ADDR{1'b1}}};
  localparam logic [NB_ADDR:0] IDX_ONE  = {{NB_ADDR{1'b0}}, 1'b1};

  state_t             state;
  logic [NB_ADDR:0]   idx;
  logic               load;
  logic               shift;
  logic [NB_BYTE-1:0] cur_byte;
  logic               last_byte;

  assign load  = (state == LOAD);
  assign shift = (state == WAIT) && i_tx_done && !last_byte;

  reg_word_serializer #(
    .NB_REG    (NB_REG),
    .NB_BYTE   (NB_BYTE),
    .MSB_FIRST (MSB_FIRST)
  ) u_serializer (
    .clk       (i_clk),
    .rst       (i_reset),
    .load      (load),
    .shift     (shift),
    .word      (i_reg_data),
    .cur_byte  (cur_byte),
    .last_byte (last_byte)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= IDLE;
      idx        <= '0;
      o_reg_addr <= '0;
      o_tx_data  <= '0;
      o_tx_start <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      o_tx_start <= 1'b0;
      o_done     <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            idx    <= '0;
            o_busy <= 1'b1;
            state  <= ADDR;
          end
        end
        ADDR: begin
          o_reg_addr <= idx[NB_ADDR-1:0];
          state      <= LOAD;
        end
        LOAD: begin
          state <= SEND;
        end
        SEND: begin
          o_tx_data  <= cur_byte;
          o_tx_start <= 1'b1;
          state      <= WAIT;
        end
        WAIT: begin
          if (i_tx_done) begin
            state <= last_byte ? NEXT : SEND;
          end
        end
        NEXT: begin
          if (idx == LAST_IDX) begin
            o_done <= 1'b1;
            state  <= DONE;
          end else begin
            idx   <= idx + IDX_ONE;
            state <= ADDR;
          end
        end
        DONE: begin
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_dump_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_regfile_dump_reader : directed bench with an MSB-first and an LSB-first |
// | reader sharing one register file and TX responder. Rev 1.0                  |
// +----------------------------------------------------------------------------+
module tb_regfile_dump_reader;
  import regfile_dump_reader_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        tx_done;
  logic [31:0] rf [32];
  logic [31:0] rd0, rd1;
  logic [4:0]  addr0, addr1;
  logic [7:0]  txd0, txd1;
  logic        txs0, txs1, busy0, busy1, done0, done1;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          done_pulses = 0;
  int          tx_delay = 5;
  int          cnt = -1;
  bit          inject_req = 1'b0;
  bit          extend = 1'b0;
  logic [7:0]  got0[$];
  logic [7:0]  got1[$];
  int          scyc[$];

  assign rd0 = rf[addr0];
  assign rd1 = rf[addr1];

  always #5 clk = ~clk;

  regfile_dump_reader #(.NB_REG(32), .NB_ADDR(5), .NB_BYTE(8), .MSB_FIRST(1)) dut0 (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_reg_data(rd0), .i_tx_done(tx_done),
    .o_reg_addr(addr0), .o_tx_data(txd0), .o_tx_start(txs0), .o_busy(busy0), .o_done(done0)
  );

  regfile_dump_reader #(.NB_REG(32), .NB_ADDR(5), .NB_BYTE(8), .MSB_FIRST(0)) dut1 (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_reg_data(rd1), .i_tx_done(tx_done),
    .o_reg_addr(addr1), .o_tx_data(txd1), .o_tx_start(txs1), .o_busy(busy1), .o_done(done1)
  );

  // TX responder and byte monitor, sampled on the falling edge.
  initial begin
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      tx_done = 1'b0;
      if (done0) done_pulses++;
      if (rst) begin
        cnt    = -1;
        extend = 1'b0;
      end else begin
        if (extend) begin
          tx_done = 1'b1;
          extend  = 1'b0;
        end
        if (txs0) begin
          got0.push_back(txd0);
          got1.push_back(txd1);
          scyc.push_back(cyc);
          cnt = tx_delay;
        end else if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            tx_done = 1'b1;
            cnt     = -1;
            if (inject_req && (((got0.size() - 1) % 4) != 3)) begin
              extend     = 1'b1;
              inject_req = 1'b0;
            end
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] msb_byte(input logic [31:0] v, input int j);
    return 8'(v >> (8 * (3 - j)));
  endfunction

  function automatic logic [7:0] lsb_byte(input logic [31:0] v, input int j);
    return 8'(v >> (8 * j));
  endfunction

  task automatic check_stream(input string tag);
    int bad0 = 0;
    int bad1 = 0;
    for (int i = 0; i < got0.size() && i < 128; i++) begin
      logic [31:0] v;
      v = 32'h1000_0000 + 32'(i / 4);
      if (got0[i] !== msb_byte(v, i % 4)) bad0++;
      if (got1[i] !== lsb_byte(v, i % 4)) bad1++;
    end
    check({tag, "_bytes"}, 64'(got0.size()), 64'd128);
    check({tag, "_msb_bad"}, 64'(bad0), 64'd0);
    check({tag, "_lsb_bad"}, 64'(bad1), 64'd0);
  endtask

  task automatic wait_bytes(input int n, input string tag);
    int k = 0;
    while (got0.size() < n && k < 5000) begin
      @(negedge clk);
      k++;
    end
    if (got0.size() < n) check(tag, 64'(got0.size()), 64'(n));
  endtask

  task automatic wait_done(input int target, input string tag);
    int k = 0;
    while (done_pulses < target && k < 5000) begin
      @(negedge clk);
      k++;
    end
    check(tag, 64'(done_pulses), 64'(target));
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic clear_log();
    got0.delete();
    got1.delete();
    scyc.delete();
  endtask

  initial begin
    int n;
    int held;
    rst   = 1'b1;
    start = 1'b0;
    for (int k = 0; k < 32; k++) rf[k] = 32'h1000_0000 + 32'(k);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_start", 64'(txs0), 64'd0);
    check("rst_tx_data", 64'(txd0), 64'd0);
    check("rst_reg_addr", 64'(addr0), 64'd0);
    check("rst_busy", 64'(busy0), 64'd0);
    check("rst_done", 64'(done0), 64'd0);
    check("rst_lsb_idle", 64'({busy1, done1, txs1}), 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Full dump, TX answering 5 cycles after each start; reg 5 rewritten mid-send
    tx_delay = 5;
    clear_log();
    pulse_start();
    wait_bytes(21, "A_reach_reg5");
    rf[5] = 32'hDEAD_BEEF;
    wait_done(1, "A_done_pulse");
    repeat (3) @(negedge clk);
    check("A_busy_low", 64'(busy0), 64'd0);
    check("A_single_done", 64'(done_pulses), 64'd1);
    check("A_addr_held", 64'(addr0), 64'd31);
    check_stream("A");
    rf[5] = 32'h1000_0005;

    // Latency, restart request while busy and a spurious done in a SEND cycle
    tx_delay = 2;
    clear_log();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("B_busy_after_start", 64'(busy0), 64'd1);
    n = 0;
    while (!txs0 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check("B_first_start_edges", 64'(n), 64'd3);
    check("B_first_addr", 64'(addr0), 64'd0);
    wait_bytes(40, "B_reach_byte40");
    @(posedge clk); #1 start = 1'b1;
    inject_req = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(2, "B_done_pulse");
    repeat (3) @(negedge clk);
    check("B_single_done", 64'(done_pulses), 64'd2);
    check("B_gap_in_word", 64'(scyc[1] - scyc[0]), 64'd4);
    check("B_gap_across_word", 64'(scyc[4] - scyc[3]), 64'd7);
    check("B_inject_used", 64'(inject_req), 64'd0);
    check_stream("B");

    // Byte order of a distinctive word, then reset during reg 7
    tx_delay = 5;
    clear_log();
    rf[3] = 32'hAABB_CCDD;
    pulse_start();
    wait_bytes(29, "C_reach_reg7");
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    check("C_rst_tx_start", 64'(txs0), 64'd0);
    check("C_rst_tx_data", 64'(txd0), 64'd0);
    check("C_rst_reg_addr", 64'(addr0), 64'd0);
    check("C_rst_busy", 64'(busy0), 64'd0);
    check("C_rst_done", 64'(done0), 64'd0);
    check("C_rst_state", 64'(dut0.state), 64'(IDLE));
    rst = 1'b0;
    check("C_reg3_msb", 64'({got0[12], got0[13], got0[14], got0[15]}), 64'h0000_0000_AABB_CCDD);
    check("C_reg3_lsb", 64'({got1[12], got1[13], got1[14], got1[15]}), 64'h0000_0000_DDCC_BBAA);
    held = got0.size();
    repeat (20) @(negedge clk);
    check("C_no_tx_after_rst", 64'(got0.size()), 64'(held));
    check("C_no_done", 64'(done_pulses), 64'd2);
    rf[3] = 32'h1000_0003;

    // Fresh dump after the abort starts again from register 0
    clear_log();
    pulse_start();
    wait_done(3, "D_done_pulse");
    check_stream("D");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
